// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants: response encodings and strobe width.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_STRB_W = 4;
endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite five-channel bundle; master drives requests, slave drives responses.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [2:0]            AWPROT;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [AXI_STRB_W-1:0] WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// Register storage: one byte-strobed write port, one combinational read port,
// and the full contents exported flat.
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    parameter  int DATA_W   = 32,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [AXI_STRB_W-1:0]      wr_strb,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
    logic [DATA_W-1:0] mem [NUM_REGS];

    // NOTE: this array is reset on purpose; software expects every control register to read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[i*DATA_W +: DATA_W] = mem[i];
    end
endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave terminating all five channels into a bank of NUM_REGS
// 32-bit registers; write and read paths are fully independent.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_LSB = 2
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    axi_lite_if.slave                  bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
    localparam int IDX_W = $clog2(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> (ADDR_LSB + IDX_W)) == '0;
    endfunction

    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx;
    logic                  aw_ok;
    logic [DATA_W-1:0]     w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic [DATA_W-1:0]     rd_data;
    logic                  commit;
    logic                  unused_prot;

    assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

    assign bus.AWREADY = !aw_held && !bvalid;
    assign bus.WREADY  = !w_held && !bvalid;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp;
    assign bus.ARREADY = !rvalid;
    assign bus.RVALID  = rvalid;
    assign bus.RDATA   = rdata;
    assign bus.RRESP   = rresp;

    assign commit = aw_held && w_held;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid && bus.BREADY) begin
                bvalid <= 1'b0;
            end

            if (bus.AWVALID && bus.AWREADY) begin
                aw_held <= 1'b1;
                aw_idx  <= bus.AWADDR[ADDR_LSB +: IDX_W];
                aw_ok   <= in_range(bus.AWADDR);
            end
            if (bus.WVALID && bus.WREADY) begin
                w_held <= 1'b1;
                w_data <= bus.WDATA;
                w_strb <= bus.WSTRB;
            end
        end
    end

    // Read data comes from the pre-edge register contents, so a read sampled
    // on a commit edge returns the old value.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (bus.ARVALID && !rvalid) begin
            rvalid <= 1'b1;
            rdata  <= in_range(bus.ARADDR) ? rd_data : '0;
            rresp  <= in_range(bus.ARADDR) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid && bus.RREADY) begin
            rvalid <= 1'b0;
        end
    end

    axi_lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_bank (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .we        (commit && aw_ok),
        .wr_idx    (aw_idx),
        .wr_strb   (w_strb),
        .wr_data   (w_data),
        .rd_idx    (bus.ARADDR[ADDR_LSB +: IDX_W]),
        .rd_data   (rd_data),
        .regs_flat (regs_flat)
    );
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: stimulus queues expected B/R
// responses, a monitor pops and compares them on every handshake.
module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] regs_flat;
    logic [255:0] exp_flat;

    logic [1:0] b_q[$];
    r_exp_t     r_q[$];
    int tests = 0, fails = 0, b_seen = 0, r_seen = 0;
    int b0, r0;

    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_slave_regs #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .ADDR_LSB(2)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .bus       (bus.slave),
        .regs_flat (regs_flat)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got no handshake expected handshake within 50 cycles", name);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Handshake tasks start at posedge+1 and return at posedge+1 of the handshake edge.
    task automatic do_aw(input logic [31:0] addr);
        bus.AWADDR = addr;
        bus.AWVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.AWREADY) begin
                @(posedge clk); #1;
                bus.AWVALID = 1'b0;
                return;
            end
        end
        bus.AWVALID = 1'b0;
        timeout_fail("aw_timeout");
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb);
        bus.WDATA = data;
        bus.WSTRB = strb;
        bus.WVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.WREADY) begin
                @(posedge clk); #1;
                bus.WVALID = 1'b0;
                return;
            end
        end
        bus.WVALID = 1'b0;
        timeout_fail("w_timeout");
    endtask

    task automatic do_ar(input logic [31:0] addr);
        bus.ARADDR = addr;
        bus.ARVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.ARREADY) begin
                @(posedge clk); #1;
                bus.ARVALID = 1'b0;
                return;
            end
        end
        bus.ARVALID = 1'b0;
        timeout_fail("ar_timeout");
    endtask

    initial begin : monitor
        logic [1:0] be;
        r_exp_t     re;
        forever begin
            @(negedge clk);
            if (rst_n && bus.BVALID && bus.BREADY) begin
                b_seen++;
                if (b_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected: got bresp %0h expected no response", bus.BRESP);
                end else begin
                    be = b_q.pop_front();
                    check("bresp", bus.BRESP, be);
                end
            end
            if (rst_n && bus.RVALID && bus.RREADY) begin
                r_seen++;
                if (r_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: got rdata %0h expected no response", bus.RDATA);
                end else begin
                    re = r_q.pop_front();
                    check("rdata", bus.RDATA, re.data);
                    check("rresp", bus.RRESP, re.resp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.AWVALID = 0; bus.AWADDR = 0; bus.AWPROT = 0;
        bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
        bus.BREADY = 1;
        bus.ARVALID = 0; bus.ARADDR = 0; bus.ARPROT = 0;
        bus.RREADY = 1;
        exp_flat = '0;

        // Reset state
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_bresp", bus.BRESP, 0);
        check("rst_rresp", bus.RRESP, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        check("rst_regs", regs_flat, '0);

        // AW and W in the same cycle: BVALID one cycle after the handshake
        b_q.push_back(RESP_OKAY);
        fork
            do_aw(32'h04);
            do_w(32'hDEADBEEF, 4'hF);
        join
        @(negedge clk); check("t1_bvalid_edge_n", bus.BVALID, 0);
        @(negedge clk); check("t1_bvalid_edge_n1", bus.BVALID, 1);
        @(negedge clk); check("t1_bvalid_cleared", bus.BVALID, 0);
        check("t1_reg1", regs_flat[63:32], 32'hDEADBEEF);
        exp_flat[63:32] = 32'hDEADBEEF;
        @(posedge clk); #1;

        // W two cycles ahead of AW, partial strobe
        b_q.push_back(RESP_OKAY);
        b0 = b_seen;
        do_w(32'h11223344, 4'h5);
        repeat (2) begin
            @(negedge clk);
            check("t2_wready_held", bus.WREADY, 0);
            check("t2_no_bvalid", bus.BVALID, 0);
        end
        @(posedge clk); #1;
        do_aw(32'h08);
        cycles(4);
        check("t2_reg2", regs_flat[95:64], 32'h00220044);
        check("t2_single_b", b_seen - b0, 1);
        check("t2_wready_back", bus.WREADY, 1);
        exp_flat[95:64] = 32'h00220044;

        // Out-of-range write and read
        b_q.push_back(RESP_SLVERR);
        fork
            do_aw(32'h40);
            do_w(32'hFFFFFFFF, 4'hF);
        join
        cycles(3);
        check("t3_regs_unchanged", regs_flat, exp_flat);
        r_q.push_back('{data: 32'h0, resp: RESP_SLVERR});
        do_ar(32'h40);
        cycles(2);
        r_q.push_back('{data: 32'h00220044, resp: RESP_OKAY});
        do_ar(32'h08);
        cycles(2);

        // Read on the commit edge of a write to the same register sees the old value
        b_q.push_back(RESP_OKAY);
        r_q.push_back('{data: 32'h0, resp: RESP_OKAY});
        fork
            do_aw(32'h0C);
            do_w(32'hCAFEF00D, 4'hF);
            begin
                @(posedge clk); #1;
                do_ar(32'h0C);
            end
        join
        cycles(3);
        exp_flat[127:96] = 32'hCAFEF00D;
        r_q.push_back('{data: 32'hCAFEF00D, resp: RESP_OKAY});
        do_ar(32'h0C);
        cycles(2);

        // Read held by RREADY low for 3 cycles
        bus.RREADY = 1'b0;
        r_q.push_back('{data: 32'hDEADBEEF, resp: RESP_OKAY});
        do_ar(32'h04);
        repeat (3) begin
            @(negedge clk);
            check("t4_rvalid_hold", bus.RVALID, 1);
            check("t4_rdata_hold", bus.RDATA, 32'hDEADBEEF);
            check("t4_arready_low", bus.ARREADY, 0);
        end
        @(posedge clk); #1;
        bus.RREADY = 1'b1;
        @(negedge clk); check("t4_arready_before_hs", bus.ARREADY, 0);
        @(negedge clk); check("t4_arready_after_hs", bus.ARREADY, 1);
        check("t4_rvalid_cleared", bus.RVALID, 0);
        @(posedge clk); #1;

        // BREADY low blocks further AW/W
        bus.BREADY = 1'b0;
        b_q.push_back(RESP_OKAY);
        b_q.push_back(RESP_OKAY);
        fork
            do_aw(32'h10);
            do_w(32'h55AA55AA, 4'hF);
        join
        @(negedge clk);
        @(negedge clk); check("t5_bvalid", bus.BVALID, 1);
        @(posedge clk); #1;
        fork
            do_aw(32'h14);
            do_w(32'h01020304, 4'hC);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t5_aw_w_blocked", {bus.AWREADY, bus.WREADY}, 2'b00);
                    check("t5_bvalid_hold", bus.BVALID, 1);
                end
                @(posedge clk); #1;
                bus.BREADY = 1'b1;
            end
        join
        cycles(4);
        exp_flat[159:128] = 32'h55AA55AA;
        exp_flat[191:160] = 32'h01020000;
        check("t5_regs", regs_flat, exp_flat);

        // All-zero strobe completes OKAY and changes nothing
        b_q.push_back(RESP_OKAY);
        fork
            do_aw(32'h10);
            do_w(32'hFFFFFFFF, 4'h0);
        join
        cycles(4);
        check("t6_zero_strb_regs", regs_flat, exp_flat);

        // Reset with both responses pending
        bus.BREADY = 1'b0;
        bus.RREADY = 1'b0;
        fork
            do_aw(32'h18);
            do_w(32'h12345678, 4'hF);
            do_ar(32'h04);
        join
        cycles(2);
        check("t7_pending", {bus.BVALID, bus.RVALID}, 2'b11);
        b0 = b_seen;
        r0 = r_seen;
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        check("t7_rst_regs", regs_flat, '0);
        check("t7_rst_rdata", bus.RDATA, 0);
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(6);
        check("t7_no_stale_b", b_seen - b0, 0);
        check("t7_no_stale_r", r_seen - r0, 0);
        check("t7_regs_after", regs_flat, '0);
        check("b_queue_drained", b_q.size(), 0);
        check("r_queue_drained", r_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
